bgr_startup_ctrl: RTL and testbench
===================================

# bgr_startup_ctrl

Digital start-up sequencer that sits directly upstream of the bandgap reference and drives its `porst` kick input. It pulses `porst` to force the mirror gate node low and break the zero-current state. It then waits for the core to settle and qualifies an external `vbg_ok` comparator flag. It raises `bgr_ready` for downstream consumers, retries a bounded number of times, and re-kicks if the reference collapses during operation.

## Interface
Parameters:
- `KICK_CYCLES`, 4: length of each `porst` pulse in clocks (≥1).
- `SETTLE_CYCLES`, 16: wait after the kick before sampling `vbg_ok` (≥1).
- `MAX_RETRIES`, 2: failed checks tolerated before FAULT. Total kicks = MAX_RETRIES+1.
- `DROP_CYCLES`, 3: consecutive low synced `vbg_ok` cycles in READY that trigger a re-kick (≥1).
- `CNT_W`, 16: width of the timing counter. Must hold max(KICK, SETTLE, DROP).

Ports:
- `clk` input 1: single clock domain.
- `rst_n` input 1: reset, asynchronous and active-low.
- `en` input 1: sequencer enable. Level-sensitive.
- `vbg_ok` input 1: asynchronous comparator flag, 1 when vbg is in window.
- `porst` output 1: kick to the BGR start-up NFET. Active high. Registered.
- `bgr_ready` output 1: reference valid. Registered.
- `fault` output 1: start-up failed. Sticky until `en` is low.
- `retry_cnt` output 2: failed checks in the current start-up attempt. Saturates at MAX_RETRIES.

## Operation
- `vbg_ok` passes through a 2-flop synchronizer. All decisions use the synced value `ok_s`.
- State machine: IDLE, KICK, SETTLE, CHECK, READY, FAULT.
- IDLE: all outputs 0, counters cleared. `en`=1 → KICK, counter loaded with KICK_CYCLES-1.
- KICK: `porst`=1. Counter at 0 → SETTLE, counter loaded with SETTLE_CYCLES-1.
- SETTLE: `porst`=0. Counter at 0 → CHECK.
- CHECK (one cycle), three outcomes:
  - `ok_s`=1 → READY, `retry_cnt` cleared.
  - `ok_s`=0 and `retry_cnt`<MAX_RETRIES → `retry_cnt`+1, then KICK.
  - `ok_s`=0 and `retry_cnt`==MAX_RETRIES → FAULT.
- READY: `bgr_ready`=1.
  - Drop counter increments on `ok_s`=0 and clears on `ok_s`=1.
  - Reaching DROP_CYCLES → KICK with `retry_cnt`=0; `bgr_ready` drops the same edge.
- FAULT: `fault`=1, `porst`=0, `bgr_ready`=0. Exits only through `en`=0.
- `en`=0 in any state → IDLE on the next edge. This overrides every other transition, including mid-kick: `porst` drops immediately.
- `porst`, `bgr_ready` and `fault` are one-hot-or-zero. They are never high together.

## Timing
- Reset values: `porst`=0, `bgr_ready`=0, `fault`=0, `retry_cnt`=0, state IDLE, synchronizer flops 0.
- `en` sampled high at edge N → `porst` high from edge N+1 for exactly KICK_CYCLES cycles.
- SETTLE lasts exactly SETTLE_CYCLES cycles. CHECK lasts 1 cycle.
- `bgr_ready` rises at edge N+1+KICK+SETTLE+1 on first-try success.
- `vbg_ok` to `ok_s` latency is 2 cycles. Pulses on `vbg_ok` shorter than 1 cycle may be missed, which is acceptable.
- READY drop detection:
  - `ok_s` low for DROP_CYCLES consecutive samples → `porst` high on the following edge.
  - A single high sample inside the window resets the drop count.
- Mid-sequence reset: asserting `rst_n` forces the reset values asynchronously. Release is synchronous to `clk`.

## Structure
- Package `bgr_ctrl_pkg` holds:
  - the `bgr_state_t` enum (IDLE, KICK, SETTLE, CHECK, READY, FAULT; 3-bit encoding);
  - default parameter constants.
- Sub-module `sync_2ff` is the `vbg_ok` synchronizer, with async active-low reset to 0.
- One shared down-counter serves KICK and SETTLE. A separate drop counter serves READY.

## Test plan
All scenarios use the default parameters.
- **First-try success.** Reset, `en`=1, `vbg_ok`=1 throughout → `porst` high for 4 cycles, 16 idle cycles, `bgr_ready`=1 at cycle 22 after `en`; `retry_cnt`=0.
- **Fault after retries.** `vbg_ok`=0 always → three `porst` pulses, each 4 cycles and spaced 21 cycles start to start; `retry_cnt` goes 1 then 2; `fault`=1 after the third CHECK; `porst` stays 0 afterwards.
- **Brownout recovery.** In READY, drop `vbg_ok` for 2 cycles then restore → no re-kick. Drop it for 4 cycles → `bgr_ready` falls and a new 4-cycle `porst` pulse occurs.
- **Abort mid-kick.** `en` deasserted on the 2nd cycle of KICK → `porst`=0 on the next edge, state IDLE. Re-asserting `en` gives a full 4-cycle pulse.
- **Fault clear.** From FAULT, `en`=0 for 1 cycle then 1 → `fault`=0, `retry_cnt`=0, a new sequence starts.
- **Async reset mid-SETTLE.** `rst_n` low → all outputs 0 immediately, without waiting for a clock edge. Releasing with `en`=1 restarts from KICK.

Source files
------------

// File: rtl/bgr_ctrl_pkg.sv
// Shared types and default timing constants for the bandgap start-up sequencer.
//   bgr_state_t : sequencer state encoding (3 bits)
//   DEF_*       : default parameter values used by bgr_startup_ctrl
package bgr_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KICK   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_READY  = 3'd4,
    ST_FAULT  = 3'd5
  } bgr_state_t;

  localparam int unsigned DEF_KICK_CYCLES   = 4;
  localparam int unsigned DEF_SETTLE_CYCLES = 16;
  localparam int unsigned DEF_MAX_RETRIES   = 2;
  localparam int unsigned DEF_DROP_CYCLES   = 3;
  localparam int unsigned DEF_CNT_W         = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk   : destination clock
//   rst_n : async active-low reset, both flops clear to 0
//   d_i   : asynchronous input
//   q_o   : synchronized output, 2-cycle latency
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/bgr_startup_ctrl.sv
// Bandgap start-up sequencer: kicks the BGR out of its zero-current state,
// waits for it to settle, qualifies vbg_ok, retries a bounded number of
// times and re-kicks if the reference collapses while ready.
//   clk       : system clock
//   rst_n     : async active-low reset
//   en        : sequencer enable (level); low forces IDLE on the next edge
//   vbg_ok    : asynchronous comparator flag, synchronized internally
//   porst     : kick pulse to the BGR start-up NFET (registered)
//   bgr_ready : reference valid (registered)
//   fault     : start-up failed, held until en goes low (registered)
//   retry_cnt : failed checks in the current attempt, saturates at MAX_RETRIES
//
// state  | meaning
// IDLE   | disabled, counters cleared
// KICK   | porst asserted for KICK_CYCLES
// SETTLE | porst released, wait SETTLE_CYCLES
// CHECK  | one-cycle evaluation of synced vbg_ok
// READY  | reference valid, watching for a sustained drop
// FAULT  | retries exhausted, wait for en low
import bgr_ctrl_pkg::*;

module bgr_startup_ctrl #(
  parameter int unsigned KICK_CYCLES   = DEF_KICK_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int unsigned DROP_CYCLES   = DEF_DROP_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       vbg_ok,
  output logic       porst,
  output logic       bgr_ready,
  output logic       fault,
  output logic [1:0] retry_cnt
);

  localparam logic [CNT_W-1:0] KICK_LOAD   = CNT_W'(KICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DROP_LAST   = CNT_W'(DROP_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);

  logic ok_s;

  bgr_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [1:0]       retry_q, retry_d;
  logic             porst_q, ready_q, fault_q;

  sync_2ff u_sync_vbg (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (vbg_ok),
    .q_o   (ok_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    retry_d = retry_q;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      drop_d  = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_KICK;
          cnt_d   = KICK_LOAD;
          drop_d  = '0;
          retry_d = '0;
        end
        ST_KICK: begin
          if (cnt_q == '0) begin
            state_d = ST_SETTLE;
            cnt_d   = SETTLE_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_d = ST_CHECK;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (ok_s) begin
            state_d = ST_READY;
            retry_d = '0;
            drop_d  = '0;
          end else if (retry_q < RETRY_MAX) begin
            state_d = ST_KICK;
            cnt_d   = KICK_LOAD;
            retry_d = retry_q + 2'd1;
          end else begin
            state_d = ST_FAULT;
          end
        end
        ST_READY: begin
          if (ok_s) begin
            drop_d = '0;
          end else if (drop_q == DROP_LAST) begin
            // sustained collapse: start a fresh attempt with a clean retry budget
            state_d = ST_KICK;
            cnt_d   = KICK_LOAD;
            retry_d = '0;
            drop_d  = '0;
          end else begin
            drop_d = drop_q + CNT_W'(1);
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          drop_d  = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the present state and registered, so they trail
  // the state by one edge; en low clears them on the same edge that sends the
  // state to IDLE so an aborted kick ends immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      drop_q  <= '0;
      retry_q <= '0;
      porst_q <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      retry_q <= retry_d;
      if (!en) begin
        porst_q <= 1'b0;
        ready_q <= 1'b0;
        fault_q <= 1'b0;
      end else begin
        porst_q <= (state_q == ST_KICK);
        ready_q <= (state_q == ST_READY);
        fault_q <= (state_q == ST_FAULT);
      end
    end
  end

  assign porst     = porst_q;
  assign bgr_ready = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_bgr_startup_ctrl.sv
module tb_bgr_startup_ctrl;

  localparam int KICK   = 4;
  localparam int SETTLE = 16;
  localparam int MAXR   = 2;
  localparam int DROP   = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       vbg_ok;
  logic       porst;
  logic       bgr_ready;
  logic       fault;
  logic [1:0] retry_cnt;

  int checks = 0;
  int failures = 0;

  bgr_startup_ctrl #(
    .KICK_CYCLES  (KICK),
    .SETTLE_CYCLES(SETTLE),
    .MAX_RETRIES  (MAXR),
    .DROP_CYCLES  (DROP),
    .CNT_W        (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .vbg_ok    (vbg_ok),
    .porst     (porst),
    .bgr_ready (bgr_ready),
    .fault     (fault),
    .retry_cnt (retry_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Timeline reference model: an attempt starting at edge t_start kicks during
  // elapsed 1..KICK and is judged at elapsed KICK+SETTLE+1. Output values after
  // an edge reflect the mode held before that edge.
  int mode;   // 0 off, 1 attempting, 2 ready, 3 failed
  int t_now, t_start, m_retry, m_drop;
  bit hist1, hist2;
  bit e_porst, e_ready, e_fault;
  bit use_model;

  task automatic model_reset();
    mode = 0; t_now = 0; t_start = 0; m_retry = 0; m_drop = 0;
    hist1 = 0; hist2 = 0;
    e_porst = 0; e_ready = 0; e_fault = 0;
  endtask

  task automatic model_edge(input bit en_v, input bit vbg_v);
    bit ok;
    int el;
    t_now++;
    ok = hist2; hist2 = hist1; hist1 = vbg_v;
    if (!en_v) begin
      e_porst = 0; e_ready = 0; e_fault = 0;
      mode = 0; m_retry = 0; m_drop = 0;
    end else begin
      el = t_now - t_start;
      e_porst = (mode == 1) && (el >= 1) && (el <= KICK);
      e_ready = (mode == 2);
      e_fault = (mode == 3);
      case (mode)
        0: begin mode = 1; t_start = t_now; end
        1: if (el == KICK + SETTLE + 1) begin
             if (ok) begin mode = 2; m_retry = 0; m_drop = 0; end
             else if (m_retry < MAXR) begin m_retry++; t_start = t_now; end
             else mode = 3;
           end
        2: if (!ok) begin
             m_drop++;
             if (m_drop == DROP) begin mode = 1; t_start = t_now; m_retry = 0; m_drop = 0; end
           end else m_drop = 0;
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    bit en_v, vbg_v;
    en_v = en; vbg_v = vbg_ok;
    @(posedge clk);
    model_edge(en_v, vbg_v);
    #1;
    if (use_model) begin
      chk("model_porst", porst, e_porst);
      chk("model_ready", bgr_ready, e_ready);
      chk("model_fault", fault, e_fault);
      chk("model_retry", retry_cnt, m_retry);
    end
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_porst", porst, 0);
    chk("arst_ready", bgr_ready, 0);
    chk("arst_fault", fault, 0);
    chk("arst_retry", retry_cnt, 0);
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    bit       en;
    bit       vbg;
    int       n;
    bit       porst;
    bit       ready;
    bit       fault;
    int       retry;
  } vec_t;

  vec_t tbl[$];
  int cnt_p, cnt_r;

  initial begin
    // first-try success, then disable
    tbl.push_back('{1,1, 1, 0,0,0,0});
    tbl.push_back('{1,1, 4, 1,0,0,0});
    tbl.push_back('{1,1,17, 0,0,0,0});
    tbl.push_back('{1,1, 3, 0,1,0,0});
    tbl.push_back('{0,1, 1, 0,0,0,0});
    // three failed attempts, fault, fault clear, restart
    tbl.push_back('{1,0, 1, 0,0,0,0});
    tbl.push_back('{1,0, 4, 1,0,0,0});
    tbl.push_back('{1,0,16, 0,0,0,0});
    tbl.push_back('{1,0, 1, 0,0,0,1});
    tbl.push_back('{1,0, 4, 1,0,0,1});
    tbl.push_back('{1,0,16, 0,0,0,1});
    tbl.push_back('{1,0, 1, 0,0,0,2});
    tbl.push_back('{1,0, 4, 1,0,0,2});
    tbl.push_back('{1,0,16, 0,0,0,2});
    tbl.push_back('{1,0, 1, 0,0,0,2});
    tbl.push_back('{1,0, 8, 0,0,1,2});
    tbl.push_back('{0,0, 1, 0,0,0,0});
    tbl.push_back('{1,0, 1, 0,0,0,0});
    tbl.push_back('{1,0, 4, 1,0,0,0});
    tbl.push_back('{0,0, 1, 0,0,0,0});

    rst_n = 1'b0; en = 1'b0; vbg_ok = 1'b0; use_model = 0;
    model_reset();
    #23;
    chk("reset_porst", porst, 0);
    chk("reset_ready", bgr_ready, 0);
    chk("reset_fault", fault, 0);
    chk("reset_retry", retry_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[k]) begin
      for (int c = 0; c < tbl[k].n; c++) begin
        en = tbl[k].en; vbg_ok = tbl[k].vbg;
        tick();
        chk($sformatf("tbl%0d_porst", k), porst, tbl[k].porst);
        chk($sformatf("tbl%0d_ready", k), bgr_ready, tbl[k].ready);
        chk($sformatf("tbl%0d_fault", k), fault, tbl[k].fault);
        chk($sformatf("tbl%0d_retry", k), retry_cnt, tbl[k].retry);
      end
    end

    use_model = 1;

    // brownout: short dip ignored, long dip re-kicks
    en = 1; vbg_ok = 1;
    for (int c = 0; c < 25; c++) tick();
    chk("brown_ready_up", bgr_ready, 1);
    vbg_ok = 0; tick(); tick(); vbg_ok = 1;
    cnt_p = 0;
    for (int c = 0; c < 10; c++) begin tick(); cnt_p += porst; end
    chk("brown_short_kicks", cnt_p, 0);
    chk("brown_short_ready", bgr_ready, 1);
    cnt_p = 0; cnt_r = 0; vbg_ok = 0;
    for (int c = 0; c < 34; c++) begin
      if (c == 4) vbg_ok = 1;
      tick();
      cnt_p += porst; cnt_r += (bgr_ready == 0);
    end
    chk("brown_long_kicks", cnt_p, KICK);
    chk("brown_long_lowcyc", cnt_r, KICK + SETTLE + 1);
    chk("brown_recovered", bgr_ready, 1);

    // abort mid-kick, then a full pulse
    en = 0; tick();
    en = 1; tick(); tick(); tick();
    chk("abort_kick2", porst, 1);
    en = 0; tick();
    chk("abort_porst", porst, 0);
    en = 1; cnt_p = 0;
    for (int c = 0; c < 8; c++) begin tick(); cnt_p += porst; end
    chk("abort_repulse", cnt_p, KICK);

    // async reset in the SETTLE phase of the second attempt
    en = 0; tick();
    vbg_ok = 0; en = 1;
    for (int c = 0; c < 30; c++) tick();
    chk("settle_retry1", retry_cnt, 1);
    async_reset();
    tick();
    chk("rst_restart_p0", porst, 0);
    tick();
    chk("rst_restart_p1", porst, 1);

    // randomized run against the timeline model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) vbg_ok = ~vbg_ok;
      en = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 799) == 0) async_reset();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
